// File: rtl/request_unit_fsm_if.sv
// Request-unit bus: datapath decode/hit inputs and memory-control enables.
// The master modport is the request unit; the slave modport is the datapath/memory side.
interface request_unit_fsm_if #(
  parameter int CNT_W = 32
);
  logic             iMemRe;
  logic             dMemRe;
  logic             dMemWr;
  logic             halt;
  logic             ihit;
  logic             dhit;
  logic             imemREN;
  logic             dmemREN;
  logic             dmemWEN;
  logic             pcEn;
  logic             halted;
  logic             timeout_err;
  logic [CNT_W-1:0] icount;
  logic [CNT_W-1:0] dcount;

  modport master (
    input  iMemRe, dMemRe, dMemWr, halt, ihit, dhit,
    output imemREN, dmemREN, dmemWEN, pcEn, halted, timeout_err, icount, dcount
  );

  modport slave (
    output iMemRe, dMemRe, dMemWr, halt, ihit, dhit,
    input  imemREN, dmemREN, dmemWEN, pcEn, halted, timeout_err, icount, dcount
  );
endinterface

// File: rtl/request_unit_fsm.sv
// Request unit FSM: sequences fetch and data requests, halt, and saturating access counters.
// Define REQUEST_UNIT_TIMEOUT_EN to add the miss-cycle wait counter and the sticky ERR state.
module request_unit_fsm #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  request_unit_fsm_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DATA,
`ifdef REQUEST_UNIT_TIMEOUT_EN
    ERR,
`endif
    HALT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic             opWrite;
  logic [CNT_W-1:0] icountQ;
  logic [CNT_W-1:0] dcountQ;

`ifdef REQUEST_UNIT_TIMEOUT_EN
  localparam int                WAIT_W    = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  logic [WAIT_W-1:0] waitCnt;
`endif

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      opWrite <= 1'b0;
      icountQ <= '0;
      dcountQ <= '0;
`ifdef REQUEST_UNIT_TIMEOUT_EN
      waitCnt <= '0;
`endif
    end else begin
`ifdef REQUEST_UNIT_TIMEOUT_EN
      // Only consecutive miss cycles keep the count alive; everything else clears it.
      waitCnt <= '0;
`endif
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (bus.ihit) begin
            icountQ <= satInc(icountQ);
            if (bus.halt) begin
              state <= HALT;
            end else if (bus.dMemWr) begin
              state   <= DATA;
              opWrite <= 1'b1;
            end else if (bus.dMemRe) begin
              state   <= DATA;
              opWrite <= 1'b0;
            end
          end
`ifdef REQUEST_UNIT_TIMEOUT_EN
          else if (bus.iMemRe) begin
            if (waitCnt == WAIT_LAST) state <= ERR;
            else                      waitCnt <= waitCnt + 1'b1;
          end
`endif
        end
        DATA: begin
          if (bus.dhit) begin
            dcountQ <= satInc(dcountQ);
            state   <= FETCH;
          end
`ifdef REQUEST_UNIT_TIMEOUT_EN
          else if (waitCnt == WAIT_LAST) state <= ERR;
          else                           waitCnt <= waitCnt + 1'b1;
`endif
        end
        default: state <= state;
      endcase
    end
  end

  // Enables follow the registered state; pcEn tracks the hit in the same cycle.
  assign bus.imemREN = (state == FETCH) & bus.iMemRe;
  assign bus.dmemREN = (state == DATA) & ~opWrite;
  assign bus.dmemWEN = (state == DATA) & opWrite;
  assign bus.pcEn    = ((state == FETCH) & bus.ihit & ~bus.halt & ~bus.dMemWr & ~bus.dMemRe)
                     | ((state == DATA) & bus.dhit);
  assign bus.halted  = (state == HALT);
`ifdef REQUEST_UNIT_TIMEOUT_EN
  assign bus.timeout_err = (state == ERR);
`else
  assign bus.timeout_err = 1'b0;
`endif
  assign bus.icount = icountQ;
  assign bus.dcount = dcountQ;

endmodule

// File: tb/tb_request_unit_fsm.sv
// Scoreboard bench for request_unit_fsm: a behavioural model queues expected outputs per cycle,
// a monitor compares two DUTs (wide counters and 3-bit saturating counters) against them.
module tb_request_unit_fsm;

  localparam int TIMEOUT = 4;
`ifdef REQUEST_UNIT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic nRST;
  always #5 clk = ~clk;

  request_unit_fsm_if #(.CNT_W(32)) busA ();
  request_unit_fsm_if #(.CNT_W(3))  busS ();

  assign busS.iMemRe = busA.iMemRe;
  assign busS.dMemRe = busA.dMemRe;
  assign busS.dMemWr = busA.dMemWr;
  assign busS.halt   = busA.halt;
  assign busS.ihit   = busA.ihit;
  assign busS.dhit   = busA.dhit;

  request_unit_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
    .CLK (clk),
    .nRST(nRST),
    .bus (busA)
  );

  request_unit_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(3)) dutSat (
    .CLK (clk),
    .nRST(nRST),
    .bus (busS)
  );

  typedef struct {
    bit     imem;
    bit     dre;
    bit     dwe;
    bit     pc;
    bit     hlt;
    bit     terr;
    longint ic;
    longint dc;
  } exp_t;

  exp_t q[$];
  int   nChecks = 0;
  int   nFails  = 0;

  // Behavioural model: what the core is doing, not how the FSM encodes it.
  bit     mRun;   // out of the post-reset idle cycle
  bit     mHalt;
  bit     mErr;
  int     mOp;    // pending data access: 0 none, 1 load, 2 store
  int     mMiss;  // consecutive unanswered request cycles
  longint mIc;
  longint mDc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic longint sat3(input longint v);
    return (v > 7) ? 7 : v;
  endfunction

  task automatic modelReset();
    mRun = 0; mHalt = 0; mErr = 0; mOp = 0; mMiss = 0; mIc = 0; mDc = 0;
  endtask

  task automatic missCycle();
    if (TO_EN) begin
      if (mMiss == TIMEOUT - 1) begin
        mErr  = 1;
        mMiss = 0;
      end else begin
        mMiss++;
      end
    end
  endtask

  // One clock of stimulus: drive inputs after the falling edge, queue the expected outputs
  // for this cycle, then advance the model across the next rising edge.
  task automatic step(input bit rn, input bit ih, input bit dh,
                      input bit re, input bit wr, input bit hl);
    exp_t e;
    @(negedge clk);
    nRST        = rn;
    busA.iMemRe = 1'b1;
    busA.ihit   = ih;
    busA.dhit   = dh;
    busA.dMemRe = re;
    busA.dMemWr = wr;
    busA.halt   = hl;
    e = '{imem: 0, dre: 0, dwe: 0, pc: 0, hlt: 0, terr: 0, ic: 0, dc: 0};
    if (!rn) begin
      modelReset();
    end else begin
      e.ic = mIc;
      e.dc = mDc;
      if (!mRun) begin
        mRun = 1;
      end else if (mHalt) begin
        e.hlt = 1;
      end else if (mErr) begin
        e.terr = 1;
      end else if (mOp != 0) begin
        e.dre = (mOp == 1);
        e.dwe = (mOp == 2);
        e.pc  = dh;
        if (dh) begin
          mDc++; mOp = 0; mMiss = 0;
        end else begin
          missCycle();
        end
      end else begin
        e.imem = 1;
        e.pc   = ih && !hl && !wr && !re;
        if (ih) begin
          mIc++; mMiss = 0;
          if (hl)      mHalt = 1;
          else if (wr) mOp = 2;
          else if (re) mOp = 1;
        end else begin
          missCycle();
        end
      end
    end
    q.push_back(e);
  endtask

  // Monitor: samples both DUTs mid-cycle and compares against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("imemREN",      busA.imemREN,     e.imem);
        chk("dmemREN",      busA.dmemREN,     e.dre);
        chk("dmemWEN",      busA.dmemWEN,     e.dwe);
        chk("pcEn",         busA.pcEn,        e.pc);
        chk("halted",       busA.halted,      e.hlt);
        chk("timeout_err",  busA.timeout_err, e.terr);
        chk("icount",       busA.icount,      e.ic);
        chk("dcount",       busA.dcount,      e.dc);
        chk("sat.imemREN",  busS.imemREN,     e.imem);
        chk("sat.pcEn",     busS.pcEn,        e.pc);
        chk("sat.icount",   busS.icount,      sat3(e.ic));
        chk("sat.dcount",   busS.dcount,      sat3(e.dc));
      end
    end
  end

  // Reset asserted between edges while a data access is outstanding.
  task automatic asyncMidData();
    @(negedge clk);
    #3;
    nRST = 1'b0;
    modelReset();
    #1;
    chk("async.dmemREN",  busA.dmemREN,  1'b0);
    chk("async.dmemWEN",  busA.dmemWEN,  1'b0);
    chk("async.imemREN",  busA.imemREN,  1'b0);
    chk("async.pcEn",     busA.pcEn,     1'b0);
    chk("async.icount",   busA.icount,   64'd0);
    chk("async.dcount",   busA.dcount,   64'd0);
    chk("async.sat.icnt", busS.icount,   64'd0);
  endtask

  initial begin
    nRST        = 1'b0;
    busA.iMemRe = 1'b1;
    busA.ihit   = 1'b0;
    busA.dhit   = 1'b0;
    busA.dMemRe = 1'b0;
    busA.dMemWr = 1'b0;
    busA.halt   = 1'b0;
    modelReset();

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Back-to-back non-memory instructions with zero-wait fetch
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0, 0);
    // Load with three wait cycles
    step(1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    // Store with both decode bits set
    step(1, 1, 0, 1, 1, 0);
    step(1, 0, 1, 1, 1, 1);
    step(1, 1, 0, 0, 0, 0);
    // Hit arrives on the last allowed miss cycle
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    // Fetch timeout
    for (int i = 0; i < 7; i++) step(1, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    // Data timeout
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0, 0);
    // Halt beats a store decoded alongside it
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 1, 0);
    // Reset pulsed mid-load, then fetch resumes
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    asyncMidData();
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    // Long miss run
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1000; i++) step(1, 0, 0, 0, 0, 0);
    // Randomized traffic with occasional resets
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 60) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 24) == 0));
    end

    @(negedge clk);
    #4;
    chk("queueDrained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/request_unit_fsm.md
# request_unit_fsm

Parametrised, state-machine successor to the single-cycle request unit. It sequences instruction-fetch and data-memory requests from the datapath onto the cache/memory-control enables. It holds each enable until the matching hit arrives, then drops it on the following cycle. It also handles halt, flags a memory timeout, and keeps saturating fetch and data-access counters. It sits between the datapath control unit and the memory-control interface (imemREN/dmemREN/dmemWEN, ihit/dhit).

## Interface
- TIMEOUT, default 256: consecutive miss cycles before error; must be ≥2.
- CNT_W, default 32: width of the performance counters.
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- iMemRe  input  1  instruction read wanted; ignored except in FETCH.
- dMemRe  input  1  decoded load of the current instruction; valid while ihit=1.
- dMemWr  input  1  decoded store of the current instruction; valid while ihit=1.
- halt  input  1  decoded halt of the current instruction; valid while ihit=1.
- ihit  input  1  instruction memory hit.
- dhit  input  1  data memory hit.
- imemREN  output  1  instruction read enable.
- dmemREN  output  1  data read enable.
- dmemWEN  output  1  data write enable.
- pcEn  output  1  one-cycle PC advance strobe.
- halted  output  1  core halted.
- timeout_err  output  1  sticky timeout error.
- icount  output  CNT_W  completed fetches.
- dcount  output  CNT_W  completed data accesses.

## Operation
- States: IDLE, FETCH, DATA, HALT, ERR. Reset state is IDLE.
- Enables are Moore outputs of the registered state:
  - imemREN=1 only in FETCH with iMemRe=1.
  - dmemREN / dmemWEN=1 only in DATA, selected by the latched op bit.
- IDLE: all outputs 0. Goes to FETCH on the next edge, unconditionally.
- FETCH, on ihit=1 (priority order):
  1. halt=1 → HALT. pcEn=0.
  2. dMemWr=1 → DATA with op=WRITE. Write wins if dMemRe=1 too.
  3. dMemRe=1 → DATA with op=READ.
  4. Otherwise stay in FETCH. pcEn=1 in the same cycle, combinationally with ihit.
- DATA: on dhit=1, pcEn=1 in the same cycle and → FETCH. halt, dMemRe and dMemWr are ignored.
- HALT: all enables 0, pcEn=0, halted=1. Exits only on reset.
- ERR: all enables 0, pcEn=0, timeout_err=1. Exits only on reset.
- ihit while not in FETCH, and dhit while not in DATA, are ignored.
- Wait counter:
  - Width is clog2(TIMEOUT).
  - Increments each FETCH (with iMemRe=1) or DATA cycle that has no matching hit.
  - Clears on hit, on any state change, and in every other state.
  - At the edge where the counter equals TIMEOUT-1 and the hit is still absent, go to ERR. A hit in that same cycle wins.
- icount increments on each accepted ihit in FETCH, including halt fetches. dcount increments on each dhit in DATA. Both saturate at all-ones and never wrap.

## Timing
- Reset values: all outputs 0, counters 0, state IDLE. Asynchronous reset forces these immediately, from any state, including mid-DATA.
- First imemREN=1 appears one cycle after nRST deasserts.
- Hit to enable drop: the enable is low on the cycle after the hit edge, so there is no duplicate request.
- Load/store instruction: ihit at cycle t → dmemREN/WEN=1 and imemREN=0 from t+1. dhit at t+k → imemREN=1 at t+k+1.
- Minimum instruction cost: 1 cycle for non-memory instructions and 2 cycles for load/store with zero-wait memory.

## Configuration
- REQUEST_UNIT_TIMEOUT_EN:
  - Defined: the wait counter and ERR state exist as above.
  - Undefined: no wait counter and no ERR state. timeout_err is tied to 0 and requests wait indefinitely. TIMEOUT is unused.

## Test plan
- Reset release, memory always ihit=1, no data ops → imemREN=1 from cycle 1. pcEn=1 every cycle. icount=10 after 10 cycles. dmemREN/WEN stay 0.
- Load: ihit with dMemRe=1, then dhit after 3 wait cycles → dmemREN=1 for exactly 4 cycles. imemREN=0 during them. pcEn pulses once on the dhit cycle. dcount=1.
- Store with dMemRe=dMemWr=1 → only dmemWEN=1. dmemREN stays 0.
- Halt: ihit with halt=1 and dMemWr=1 → HALT next cycle. halted=1, no dmemWEN, pcEn=0. Further ihit/dhit have no effect.
- TIMEOUT=4, macro defined, ihit held 0 → timeout_err=1 and imemREN=0 after exactly 4 miss cycles. With ihit=1 on the 4th cycle instead → normal fetch and no error. Macro undefined → no error after 1000 cycles.
- Saturation: CNT_W=3, 9 fetches → icount=7. nRST pulsed mid-DATA → all outputs 0 immediately, then fetch resumes.
